// File: rtl/ws2812_chain_if.sv
// Host-side bundle for ws2812_chain: frame-buffer write port, frame control and status.
interface ws2812_chain_if #(
   parameter int NUM_LEDS = 8
);
   localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [23:0]   wr_rgb;
   logic          start;
   logic          auto_refresh;
   logic          busy;
   logic          done;

   modport slave  (input  wr_en, wr_addr, wr_rgb, start, auto_refresh, output busy, done);
   modport master (output wr_en, wr_addr, wr_rgb, start, auto_refresh, input  busy, done);
endinterface

// File: rtl/ws2812_chain.sv
// WS2812 chain driver: NUM_LEDS x 24-bit frame buffer serialised as GRB, MSB first,
// LED 0 first, followed by a latch (reset) low period.
module ws2812_chain #(
   parameter int CLK_FRE  = 27_000_000,
   parameter int NUM_LEDS = 8,
   parameter int T1H_NS   = 850,
   parameter int T0H_NS   = 400,
   parameter int TBIT_NS  = 1250,
   parameter int RESET_US = 80
) (
   input  logic           clk,
   input  logic           rst_n,
   ws2812_chain_if.slave  bus,
   output logic           WS2812
);
   localparam int AW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int T1H  = int'((longint'(CLK_FRE) / 1000 * T1H_NS  + 500_000) / 1_000_000);
   localparam int T0H  = int'((longint'(CLK_FRE) / 1000 * T0H_NS  + 500_000) / 1_000_000);
   localparam int TBIT = int'((longint'(CLK_FRE) / 1000 * TBIT_NS + 500_000) / 1_000_000);
   localparam int T1L  = TBIT - T1H;
   localparam int T0L  = TBIT - T0H;
   localparam int TRST = CLK_FRE / 1_000_000 * RESET_US;
   localparam int CMAX = (TRST > TBIT) ? TRST : TBIT;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [4:0]    bit_q, bit_d;
   logic [23:0]   sh_q, sh_d;
   logic [23:0]   fb [NUM_LEDS];
   logic [23:0]   rgb;
   logic [CW-1:0] hi_end, lo_end;
   logic          done_c;

   // Frame buffer is not reset; LOAD reads the pre-write value on a same-cycle hit.
   always_ff @(posedge clk) begin
      if (bus.wr_en && ({1'b0, bus.wr_addr} < (AW+1)'(NUM_LEDS)))
         fb[bus.wr_addr] <= bus.wr_rgb;
   end

   assign rgb = fb[idx_q];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      done_c  = 1'b0;
      hi_end  = sh_q[23] ? CW'(T1H - 1) : CW'(T0H - 1);
      // The last bit of each LED is one cycle short in LOW; the following LOAD
      // (or first LATCH cycle) supplies the missing low cycle.
      lo_end  = (sh_q[23] ? CW'(T1L) : CW'(T0L)) - ((bit_q == 5'd0) ? CW'(2) : CW'(1));
      case (state_q)
         IDLE: begin
            if (bus.start || bus.auto_refresh) begin
               state_d = LOAD;
               idx_d   = '0;
            end
         end
         LOAD: begin
            sh_d    = {rgb[15:8], rgb[23:16], rgb[7:0]};
            bit_d   = 5'd23;
            cnt_d   = '0;
            state_d = HIGH;
         end
         HIGH: begin
            if (cnt_q == hi_end) begin
               cnt_d   = '0;
               state_d = LOW;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         LOW: begin
            if (cnt_q == lo_end) begin
               cnt_d = '0;
               if (bit_q == 5'd0) begin
                  if (idx_q == AW'(NUM_LEDS - 1)) begin
                     state_d = LATCH;
                  end else begin
                     idx_d   = idx_q + AW'(1);
                     state_d = LOAD;
                  end
               end else begin
                  bit_d   = bit_q - 5'd1;
                  sh_d    = {sh_q[22:0], 1'b0};
                  state_d = HIGH;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         LATCH: begin
            if (cnt_q == CW'(TRST - 1)) begin
               done_c = 1'b1;
               cnt_d  = '0;
               if (bus.auto_refresh) begin
                  idx_d   = '0;
                  state_d = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset lands in LATCH so a frame cut short by reset is still terminated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LATCH;
         cnt_q   <= '0;
         idx_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
      end
   end

   assign WS2812   = (state_q == HIGH);
   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_c;
endmodule
